// File: rtl/sgd_pkg.sv
// Shared constants and types for the SGD dispatch front end.
// Line geometry is fixed here; the engine count is overridable per instance.
package sgd_pkg;
  localparam int ENGINE_NUM         = 1;
  localparam int NUM_BITS_PER_BANK  = 64;
  localparam int NUM_OF_BANKS       = 8;
  localparam int MAX_DIMENSION_BITS = 18;
  localparam int LINE_W             = NUM_BITS_PER_BANK * NUM_OF_BANKS;
  localparam int B_HALF_W           = LINE_W / 2;
  localparam int SLICE_SHIFT        = $clog2(NUM_BITS_PER_BANK);
  localparam int GROUP_SHIFT        = $clog2(NUM_OF_BANKS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/sgd_dispatch_axb_if.sv
// Read-stream inputs and dispatch FIFO write ports of the dispatcher.
// The dispatcher uses the slave modport; reader/FIFO models use master.
interface sgd_dispatch_axb_if #(
  parameter int ENGINE_NUM = 1
);
  import sgd_pkg::*;

  logic [LINE_W-1:0]                  a_rd_data;
  logic                               a_rd_valid;
  logic                               a_rd_ready;
  logic [LINE_W-1:0]                  b_rd_data;
  logic                               b_rd_valid;
  logic                               b_rd_ready;
  logic [ENGINE_NUM-1:0][LINE_W-1:0]  dispatch_axb_a_data;
  logic [ENGINE_NUM-1:0]              dispatch_axb_a_wr_en;
  logic [ENGINE_NUM-1:0]              dispatch_axb_a_almost_full;
  logic [B_HALF_W-1:0]                dispatch_axb_b_data;
  logic                               dispatch_axb_b_wr_en;
  logic                               dispatch_axb_b_almost_full;

  modport slave (
    input  a_rd_data, a_rd_valid, b_rd_data, b_rd_valid,
    input  dispatch_axb_a_almost_full, dispatch_axb_b_almost_full,
    output a_rd_ready, b_rd_ready,
    output dispatch_axb_a_data, dispatch_axb_a_wr_en,
    output dispatch_axb_b_data, dispatch_axb_b_wr_en
  );

  modport master (
    output a_rd_data, a_rd_valid, b_rd_data, b_rd_valid,
    output dispatch_axb_a_almost_full, dispatch_axb_b_almost_full,
    input  a_rd_ready, b_rd_ready,
    input  dispatch_axb_a_data, dispatch_axb_a_wr_en,
    input  dispatch_axb_b_data, dispatch_axb_b_wr_en
  );
endinterface

// File: rtl/sgd_b_repack.sv
// Splits each 16-label B line into two 8-label writes, low half first.
// A new line is only taken once both halves of the previous one are out.
module sgd_b_repack
  import sgd_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                enable,
  input  logic [31:0]         total_writes,
  input  logic [LINE_W-1:0]   rd_data,
  input  logic                rd_valid,
  output logic                rd_ready,
  input  logic                almost_full,
  output logic [B_HALF_W-1:0] wr_data,
  output logic                wr_en,
  output logic                writes_done
);
  logic [LINE_W-1:0]   line_reg;
  logic                pend_lo_reg;
  logic                pend_hi_reg;
  logic [31:0]         line_cnt_reg;
  logic [31:0]         wr_cnt_reg;
  logic [B_HALF_W-1:0] wr_data_reg;
  logic                wr_en_reg;
  logic [31:0]         total_lines;
  logic                accept;
  logic                fire;
  logic [B_HALF_W-1:0] half_next;

  assign total_lines = total_writes >> 1;
  assign rd_ready    = enable & ~pend_lo_reg & ~pend_hi_reg & (line_cnt_reg != total_lines);
  assign accept      = rd_ready & rd_valid;

  // The low half bypasses the holding register when the FIFO has room on accept.
  always_comb begin
    fire      = 1'b0;
    half_next = line_reg[B_HALF_W-1:0];
    if (!almost_full) begin
      if (accept) begin
        fire      = 1'b1;
        half_next = rd_data[B_HALF_W-1:0];
      end else if (pend_lo_reg) begin
        fire      = 1'b1;
        half_next = line_reg[B_HALF_W-1:0];
      end else if (pend_hi_reg) begin
        fire      = 1'b1;
        half_next = line_reg[LINE_W-1:B_HALF_W];
      end
    end
  end

  // Includes the write being issued this cycle so completion lines up with its strobe.
  assign writes_done = (wr_cnt_reg + {31'd0, fire}) == total_writes;

  always_ff @(posedge clk) begin
    if (rst) begin
      line_reg     <= '0;
      pend_lo_reg  <= 1'b0;
      pend_hi_reg  <= 1'b0;
      line_cnt_reg <= '0;
      wr_cnt_reg   <= '0;
      wr_data_reg  <= '0;
      wr_en_reg    <= 1'b0;
    end else begin
      wr_en_reg <= fire;
      if (fire) wr_data_reg <= half_next;
      if (clear) begin
        line_cnt_reg <= '0;
        wr_cnt_reg   <= '0;
        pend_lo_reg  <= 1'b0;
        pend_hi_reg  <= 1'b0;
      end else begin
        if (fire) wr_cnt_reg <= wr_cnt_reg + 32'd1;
        if (accept) begin
          line_reg     <= rd_data;
          pend_lo_reg  <= almost_full;
          pend_hi_reg  <= 1'b1;
          line_cnt_reg <= line_cnt_reg + 32'd1;
        end else if (fire && pend_lo_reg) begin
          pend_lo_reg <= 1'b0;
        end else if (fire) begin
          pend_hi_reg <= 1'b0;
        end
      end
    end
  end

  assign wr_data = wr_data_reg;
  assign wr_en   = wr_en_reg;
endmodule

// File: rtl/sgd_dispatch_axb.sv
// Steers bit-sliced A lines to per-engine FIFOs, repacks B labels, and
// tracks bit/slice/group/epoch progress to signal the end of a run.
module sgd_dispatch_axb #(
  parameter int ENGINE_NUM         = sgd_pkg::ENGINE_NUM,
  parameter int MAX_DIMENSION_BITS = sgd_pkg::MAX_DIMENSION_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] dimension,
  input  logic [31:0] number_of_samples,
  input  logic [31:0] number_of_bits,
  input  logic [31:0] number_of_epochs,
  sgd_dispatch_axb_if.slave bus,
  output logic        busy,
  output logic        done,
  output logic [31:0] a_line_count
);
  import sgd_pkg::*;

  localparam int ENG_W = (ENGINE_NUM > 1) ? $clog2(ENGINE_NUM) : 1;

  state_t                        state_reg;
  state_t                        state_next;
  logic [31:0]                   bits_last_reg;
  logic [MAX_DIMENSION_BITS-1:0] slices_last_reg;
  logic [31:0]                   groups_last_reg;
  logic [31:0]                   epochs_last_reg;
  logic [31:0]                   b_total_reg;
  logic [31:0]                   bit_cnt_reg;
  logic [MAX_DIMENSION_BITS-1:0] slice_cnt_reg;
  logic [31:0]                   group_cnt_reg;
  logic [31:0]                   epoch_cnt_reg;
  logic [ENG_W-1:0]              eng_cnt_reg;
  logic                          a_finished_reg;
  logic [31:0]                   a_line_count_reg;

  logic load;
  logic running;
  logic a_ready;
  logic a_accept;
  logic bit_wrap;
  logic slice_wrap;
  logic group_wrap;
  logic a_last;
  logic b_writes_done;

  assign load       = (state_reg == IDLE) && start;
  assign running    = (state_reg == RUN);
  assign a_ready    = running && !a_finished_reg && !bus.dispatch_axb_a_almost_full[eng_cnt_reg];
  assign a_accept   = a_ready && bus.a_rd_valid;
  assign bit_wrap   = (bit_cnt_reg == bits_last_reg);
  assign slice_wrap = (slice_cnt_reg == slices_last_reg);
  assign group_wrap = (group_cnt_reg == groups_last_reg);
  assign a_last     = a_accept && bit_wrap && slice_wrap && group_wrap &&
                      (epoch_cnt_reg == epochs_last_reg);
  assign bus.a_rd_ready = a_ready;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if ((a_finished_reg || a_last) && b_writes_done) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Counters nest bit -> slice -> group -> epoch; the engine index follows the slice.
  always_ff @(posedge clk) begin
    if (rst) begin
      bits_last_reg    <= '0;
      slices_last_reg  <= '0;
      groups_last_reg  <= '0;
      epochs_last_reg  <= '0;
      b_total_reg      <= '0;
      bit_cnt_reg      <= '0;
      slice_cnt_reg    <= '0;
      group_cnt_reg    <= '0;
      epoch_cnt_reg    <= '0;
      eng_cnt_reg      <= '0;
      a_finished_reg   <= 1'b0;
      a_line_count_reg <= '0;
    end else if (load) begin
      bits_last_reg    <= number_of_bits - 32'd1;
      slices_last_reg  <= MAX_DIMENSION_BITS'((dimension >> SLICE_SHIFT) - 32'd1);
      groups_last_reg  <= (number_of_samples >> GROUP_SHIFT) - 32'd1;
      epochs_last_reg  <= number_of_epochs - 32'd1;
      b_total_reg      <= (number_of_samples >> GROUP_SHIFT) * number_of_epochs;
      bit_cnt_reg      <= '0;
      slice_cnt_reg    <= '0;
      group_cnt_reg    <= '0;
      epoch_cnt_reg    <= '0;
      eng_cnt_reg      <= '0;
      a_finished_reg   <= 1'b0;
      a_line_count_reg <= '0;
    end else if (a_accept) begin
      a_line_count_reg <= a_line_count_reg + 32'd1;
      if (a_last) a_finished_reg <= 1'b1;
      if (!bit_wrap) begin
        bit_cnt_reg <= bit_cnt_reg + 32'd1;
      end else begin
        bit_cnt_reg <= '0;
        if (!slice_wrap) begin
          slice_cnt_reg <= slice_cnt_reg + 1'b1;
          eng_cnt_reg   <= (eng_cnt_reg == ENG_W'(ENGINE_NUM - 1)) ? '0 : eng_cnt_reg + 1'b1;
        end else begin
          slice_cnt_reg <= '0;
          eng_cnt_reg   <= '0;
          if (!group_wrap) begin
            group_cnt_reg <= group_cnt_reg + 32'd1;
          end else begin
            group_cnt_reg <= '0;
            epoch_cnt_reg <= epoch_cnt_reg + 32'd1;
          end
        end
      end
    end
  end

  for (genvar gi = 0; gi < ENGINE_NUM; gi++) begin : g_lane
    logic              hit;
    logic [LINE_W-1:0] data_reg;
    logic              wr_en_reg;

    assign hit = a_accept && (eng_cnt_reg == ENG_W'(gi));

    always_ff @(posedge clk) begin
      if (rst) begin
        data_reg  <= '0;
        wr_en_reg <= 1'b0;
      end else begin
        wr_en_reg <= hit;
        if (hit) data_reg <= bus.a_rd_data;
      end
    end

    assign bus.dispatch_axb_a_data[gi]  = data_reg;
    assign bus.dispatch_axb_a_wr_en[gi] = wr_en_reg;
  end

  sgd_b_repack u_b_repack (
    .clk          (clk),
    .rst          (rst),
    .clear        (load),
    .enable       (running),
    .total_writes (b_total_reg),
    .rd_data      (bus.b_rd_data),
    .rd_valid     (bus.b_rd_valid),
    .rd_ready     (bus.b_rd_ready),
    .almost_full  (bus.dispatch_axb_b_almost_full),
    .wr_data      (bus.dispatch_axb_b_data),
    .wr_en        (bus.dispatch_axb_b_wr_en),
    .writes_done  (b_writes_done)
  );

  assign busy         = (state_reg != IDLE);
  assign done         = (state_reg == DONE);
  assign a_line_count = a_line_count_reg;
endmodule

// File: tb/tb_sgd_dispatch_axb.sv
// Randomized bench for sgd_dispatch_axb with two engines; expected A/B
// traffic is derived from line indices and the run configuration.
module tb_sgd_dispatch_axb;
  localparam int EN = 2;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] dimension;
  logic [31:0] number_of_samples;
  logic [31:0] number_of_bits;
  logic [31:0] number_of_epochs;
  logic        busy;
  logic        done;
  logic [31:0] a_line_count;

  sgd_dispatch_axb_if #(.ENGINE_NUM(EN)) bus ();

  sgd_dispatch_axb #(.ENGINE_NUM(EN), .MAX_DIMENSION_BITS(18)) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .dimension         (dimension),
    .number_of_samples (number_of_samples),
    .number_of_bits    (number_of_bits),
    .number_of_epochs  (number_of_epochs),
    .bus               (bus),
    .busy              (busy),
    .done              (done),
    .a_line_count      (a_line_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total_chk = 0;
  int bad_chk   = 0;

  // run configuration and model state
  int cfg_bits = 1, cfg_slices = 1;
  int a_total = 0, b_lines_total = 0, b_wr_total = 0;
  int a_acc_cnt = 0, a_wr_cnt = 0, b_acc_cnt = 0, b_wr_cnt = 0, done_cnt = 0;
  bit in_run = 0, b_pend = 0, busy_chk = 0, acc_prev = 0, prev_b_af = 0, af_hold = 0;
  logic [31:0]  a_seed = 32'h1234_5678;
  logic [31:0]  b_base = 32'd0;
  logic [511:0] last_lane [EN];
  int a_valid_pct = 0, b_valid_pct = 0, a_af_pct = 0, b_af_mode = 0;

  task automatic chk(string tag, logic [511:0] got, logic [511:0] exp);
    total_chk++;
    if (got !== exp) begin
      bad_chk++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] a_line(int k);
    logic [511:0] r;
    for (int j = 0; j < 16; j++)
      r[j*32 +: 32] = (32'(k) * 32'd16 + 32'(j)) * 32'h9E37_79B1 + a_seed;
    return r;
  endfunction

  function automatic logic [511:0] b_line(int m);
    logic [511:0] r;
    for (int j = 0; j < 16; j++) r[j*32 +: 32] = b_base + 32'(m * 16 + j);
    return r;
  endfunction

  // write w carries labels 8*(w%2)..8*(w%2)+7 of line w/2, label 0 lowest
  function automatic logic [255:0] b_half(int w);
    logic [255:0] r;
    for (int j = 0; j < 8; j++) r[j*32 +: 32] = b_base + 32'((w / 2) * 16 + (w % 2) * 8 + j);
    return r;
  endfunction

  function automatic int a_lane(int k);
    return ((k / cfg_bits) % cfg_slices) % EN;
  endfunction

  // input driver: random valid/backpressure, data follows the next unaccepted index
  initial begin
    bus.a_rd_valid = 1'b0;
    bus.b_rd_valid = 1'b0;
    bus.a_rd_data  = '0;
    bus.b_rd_data  = '0;
    bus.dispatch_axb_a_almost_full = '0;
    bus.dispatch_axb_b_almost_full = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.a_rd_valid = ($urandom_range(99) < a_valid_pct);
      bus.a_rd_data  = a_line(a_acc_cnt);
      bus.b_rd_valid = ($urandom_range(99) < b_valid_pct);
      bus.b_rd_data  = b_line(b_acc_cnt);
      for (int i = 0; i < EN; i++)
        bus.dispatch_axb_a_almost_full[i] = ($urandom_range(99) < a_af_pct) || (af_hold && i == 0);
      case (b_af_mode)
        1:       bus.dispatch_axb_b_almost_full = ~bus.dispatch_axb_b_almost_full;
        2:       bus.dispatch_axb_b_almost_full = ($urandom_range(99) < 30);
        default: bus.dispatch_axb_b_almost_full = 1'b0;
      endcase
    end
  end

  // monitor: compares every write, handshake and completion event with the model
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        acc_prev  = 0;
        prev_b_af = bus.dispatch_axb_b_almost_full;
      end else begin
        int  lane;
        bit  a_acc;
        bit  exp_ready;
        if (busy_chk) begin
          chk("busy_after_done", busy, 0);
          busy_chk = 0;
        end
        lane = -1;
        for (int i = 0; i < EN; i++) if (bus.dispatch_axb_a_wr_en[i]) lane = i;
        if (acc_prev || lane >= 0) begin
          chk("a_latency", lane >= 0, acc_prev);
          chk("a_onehot", $countones(bus.dispatch_axb_a_wr_en) <= 1, 1);
        end
        if (lane >= 0) begin
          chk("a_in_range", a_wr_cnt < a_total, 1);
          chk("a_lane", lane, a_lane(a_wr_cnt));
          chk("a_data", bus.dispatch_axb_a_data[lane], a_line(a_wr_cnt));
          for (int i = 0; i < EN; i++)
            if (i != lane) chk("a_hold", bus.dispatch_axb_a_data[i], last_lane[i]);
          last_lane[lane] = bus.dispatch_axb_a_data[lane];
          a_wr_cnt++;
          chk("a_line_count", a_line_count, a_wr_cnt);
          if (done_cnt == 0) chk("busy_run", busy, 1);
        end
        if (bus.dispatch_axb_b_wr_en) begin
          chk("b_gate", prev_b_af, 0);
          chk("b_in_range", b_wr_cnt < b_wr_total, 1);
          chk("b_data", bus.dispatch_axb_b_data, b_half(b_wr_cnt));
          b_wr_cnt++;
          if (b_wr_cnt % 2 == 0) b_pend = 0;
        end
        if (done) begin
          done_cnt++;
          chk("done_a", a_wr_cnt, a_total);
          chk("done_b", b_wr_cnt, b_wr_total);
          busy_chk = 1;
        end
        exp_ready = in_run && (a_acc_cnt < a_total) &&
                    !bus.dispatch_axb_a_almost_full[a_lane(a_acc_cnt)];
        chk("a_ready", bus.a_rd_ready, exp_ready);
        chk("b_ready", bus.b_rd_ready, in_run && !b_pend && (b_acc_cnt < b_lines_total));
        a_acc = bus.a_rd_valid && bus.a_rd_ready;
        if (a_acc) begin
          chk("a_over", a_acc_cnt < a_total, 1);
          a_acc_cnt++;
        end
        if (bus.b_rd_valid && bus.b_rd_ready) begin
          chk("b_over", b_acc_cnt < b_lines_total, 1);
          b_acc_cnt++;
          b_pend = 1;
        end
        acc_prev  = a_acc;
        prev_b_af = bus.dispatch_axb_b_almost_full;
      end
    end
  end

  task automatic clear_model();
    in_run = 0; b_pend = 0; busy_chk = 0; af_hold = 0;
    a_acc_cnt = 0; a_wr_cnt = 0; b_acc_cnt = 0; b_wr_cnt = 0; done_cnt = 0;
  endtask

  task automatic do_reset();
    #1 rst = 1'b1;
    in_run = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_a_ready", bus.a_rd_ready, 0);
    chk("rst_b_ready", bus.b_rd_ready, 0);
    chk("rst_a_wr_en", bus.dispatch_axb_a_wr_en, 0);
    chk("rst_b_wr_en", bus.dispatch_axb_b_wr_en, 0);
    chk("rst_b_data", bus.dispatch_axb_b_data, 0);
    chk("rst_line_count", a_line_count, 0);
    for (int i = 0; i < EN; i++) chk("rst_a_data", bus.dispatch_axb_a_data[i], 0);
    @(posedge clk);
    #1 rst = 1'b0;
    clear_model();
    for (int i = 0; i < EN; i++) last_lane[i] = '0;
  endtask

  task automatic run_cfg(int dim, int samples, int bits, int epochs, int avp, int bvp,
                         int aaf, int bafm, int abort_after, int hold_at);
    int cyc;
    bit held;
    clear_model();
    cfg_bits      = bits;
    cfg_slices    = dim / 64;
    a_total       = bits * (dim / 64) * (samples / 8) * epochs;
    b_lines_total = (samples / 16) * epochs;
    b_wr_total    = 2 * b_lines_total;
    a_seed        = $urandom;
    a_valid_pct = avp; b_valid_pct = bvp; a_af_pct = aaf; b_af_mode = bafm;
    dimension         = 32'(dim);
    number_of_samples = 32'(samples);
    number_of_bits    = 32'(bits);
    number_of_epochs  = 32'(epochs);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    in_run = 1;
    cyc = 0;
    held = 0;
    while (done_cnt == 0 && cyc < 20000) begin
      @(posedge clk);
      cyc++;
      if (abort_after > 0 && a_wr_cnt >= abort_after) begin
        do_reset();
        return;
      end
      if (hold_at > 0 && !held && a_wr_cnt >= hold_at) begin
        af_hold = 1;
        repeat (50) @(posedge clk);
        af_hold = 0;
        held = 1;
      end
    end
    chk("run_completed", done_cnt != 0, 1);
    repeat (3) @(negedge clk);
    chk("done_once", done_cnt, 1);
    chk("a_total", a_wr_cnt, a_total);
    chk("b_total", b_wr_cnt, b_wr_total);
    chk("a_line_count_end", a_line_count, a_total);
    $display("run dim=%0d samples=%0d bits=%0d epochs=%0d a_writes=%0d b_writes=%0d",
             dim, samples, bits, epochs, a_wr_cnt, b_wr_cnt);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    dimension = '0;
    number_of_samples = '0;
    number_of_bits = '0;
    number_of_epochs = '0;
    do_reset();
    b_base = 32'd0;
    run_cfg(256, 32, 4, 1, 100, 100, 0, 0, 0, 0);
    run_cfg(128, 64, 2, 1, 100, 100, 0, 1, 0, 0);
    b_base = 32'd1000;
    run_cfg(128, 16, 2, 3, 100, 100, 0, 0, 0, 0);
    run_cfg(256, 64, 4, 1, 100, 90, 0, 0, 0, 20);
    run_cfg(512, 64, 8, 1, 100, 100, 0, 0, 100, 0);
    run_cfg(256, 32, 4, 1, 100, 100, 0, 0, 0, 0);
    for (int r = 0; r < 6; r++) begin
      b_base = $urandom_range(1 << 20);
      run_cfg(128 * $urandom_range(1, 3), 16 * $urandom_range(1, 3), $urandom_range(1, 5),
              $urandom_range(1, 3), $urandom_range(40, 100), $urandom_range(30, 100),
              $urandom_range(0, 30), $urandom_range(0, 2), 0, 0);
    end
    $display("test done: total=%0d bad=%0d", total_chk, bad_chk);
    $finish;
  end
endmodule
